mmio_timer: RTL

//  Memory-mapped timer/compare peripheral that responds on the OpenMIPS data-memory bus, in parallel with data_ram.
//  The core is the only initiator on that bus (mem_ce_o/mem_we_o/mem_addr_o/mem_sel_o/mem_data_o); this block is a responder.
//  It provides a prescaled 32-bit up-counter, a compare match and an overflow flag.
//  It also provides a level interrupt request for the core's interrupt input.

---
 rtl/mmio_timer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped timer/compare peripheral on the data-memory bus.
// It has a prescaled 32-bit up-counter, a compare match flag, an overflow flag
// and a level interrupt request.
//
// Register map (addr[3:2]):
//   0x0 CTRL    [0] EN, [1] AUTO_RELOAD, [2] IE, [15:8] PRESCALE
//   0x4 COUNT   current count (R/W)
//   0x8 COMPARE match value (R/W)
//   0xC STATUS  [0] MATCH, [1] OVF (write-1-to-clear)
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ce, we        bus strobe and write enable from the core
//   addr, sel     byte address and big-endian byte-lane enables
//   data_i        write data
//   data_o        read data, combinational, 0 unless a read hits this block
//   hit_o         ce & address match, steers the core's read mux
//   irq_o         IE & (MATCH | OVF), decoded from registers only
`timescale 1ns/1ps
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hit_o,
  output logic        irq_o
);

  // Merge new data into an old word, one byte lane per sel bit.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic        ctrl_en_r;
  logic        ctrl_ar_r;
  logic        ctrl_ie_r;
  logic [7:0]  prescale_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        match_r;
  logic        ovf_r;
  logic [7:0]  pre_cnt_r;

  logic        hit_s;
  logic        wr_s;
  logic        wr_ctrl_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_status_s;
  logic [31:0] ctrl_word_s;
  logic [31:0] ctrl_new_s;
  logic [31:0] count_wdata_s;
  logic [31:0] compare_wdata_s;
  logic        tick_s;
  logic        cmp_eq_s;
  logic        set_match_s;
  logic        set_ovf_s;
  logic        clr_match_s;
  logic        clr_ovf_s;
  logic [31:0] count_next_s;
  logic [31:0] rdata_s;

  assign hit_s        = ce & (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_s         = hit_s & we;
  assign wr_ctrl_s    = wr_s & (addr[3:2] == 2'd0);
  assign wr_count_s   = wr_s & (addr[3:2] == 2'd1);
  assign wr_compare_s = wr_s & (addr[3:2] == 2'd2);
  assign wr_status_s  = wr_s & (addr[3:2] == 2'd3);

  assign ctrl_word_s     = {16'h0000, prescale_r, 5'b00000, ctrl_ie_r, ctrl_ar_r, ctrl_en_r};
  assign ctrl_new_s      = merge_lanes(ctrl_word_s, data_i, sel);
  assign count_wdata_s   = merge_lanes(count_r, data_i, sel);
  assign compare_wdata_s = merge_lanes(compare_r, data_i, sel);

  assign tick_s      = ctrl_en_r & (pre_cnt_r == prescale_r);
  assign cmp_eq_s    = (count_r == compare_r);
  // A compare match takes priority over overflow, even at COMPARE = all ones.
  assign set_match_s = tick_s & cmp_eq_s;
  assign set_ovf_s   = tick_s & ~cmp_eq_s & (count_r == 32'hFFFF_FFFF);
  assign clr_match_s = wr_status_s & sel[0] & data_i[0];
  assign clr_ovf_s   = wr_status_s & sel[0] & data_i[1];

  // Bits the decode deliberately ignores.
  logic unused_s;
  assign unused_s = &{1'b0, addr[1:0], ctrl_new_s[31:16], ctrl_new_s[7:3]};

  // Next COUNT: a bus write beats the tick; match is judged on the pre-write value.
  always_comb begin
    count_next_s = count_r;
    if (wr_count_s) begin
      count_next_s = count_wdata_s;
    end else if (tick_s) begin
      if (cmp_eq_s) begin
        count_next_s = ctrl_ar_r ? 32'h0000_0000 : count_r + 32'd1;
      end else if (count_r == 32'hFFFF_FFFF) begin
        count_next_s = 32'h0000_0000;
      end else begin
        count_next_s = count_r + 32'd1;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // CTRL register fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en_r  <= 1'b0;
      ctrl_ar_r  <= 1'b0;
      ctrl_ie_r  <= 1'b0;
      prescale_r <= 8'h00;
    end else if (wr_ctrl_s) begin
      ctrl_en_r  <= ctrl_new_s[0];
      ctrl_ar_r  <= ctrl_new_s[1];
      ctrl_ie_r  <= ctrl_new_s[2];
      prescale_r <= ctrl_new_s[15:8];
    end else begin
      ctrl_en_r  <= ctrl_en_r;
      ctrl_ar_r  <= ctrl_ar_r;
      ctrl_ie_r  <= ctrl_ie_r;
      prescale_r <= prescale_r;
    end
  end

  // Prescaler: held at 0 while disabled, restarted by any CTRL write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= 8'h00;
    end else if (wr_ctrl_s || !ctrl_en_r || tick_s) begin
      pre_cnt_r <= 8'h00;
    end else begin
      pre_cnt_r <= pre_cnt_r + 8'd1;
    end
  end

  // COUNT and COMPARE registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= 32'h0000_0000;
      compare_r <= RESET_COMPARE;
    end else begin
      count_r   <= count_next_s;
      compare_r <= wr_compare_s ? compare_wdata_s : compare_r;
    end
  end

  // STATUS flags: a hardware set wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      match_r <= set_match_s ? 1'b1 : (clr_match_s ? 1'b0 : match_r);
      ovf_r   <= set_ovf_s   ? 1'b1 : (clr_ovf_s   ? 1'b0 : ovf_r);
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (hit_s && !we) begin
      case (addr[3:2])
        2'd0:    rdata_s = ctrl_word_s;
        2'd1:    rdata_s = count_r;
        2'd2:    rdata_s = compare_r;
        2'd3:    rdata_s = {30'h0000_0000, ovf_r, match_r};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign data_o = rdata_s;
  assign hit_o  = hit_s;
  assign irq_o  = ctrl_ie_r & (match_r | ovf_r);

endmodule
